// File: rtl/pixel_write_fifo.sv
// Buffers the rasterizer's framebuffer address stream, filters off-screen and repeated
// pixels, and writes the survivors with the primitive colour to the SRAM port.
module pixel_write_fifo #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STOP_MARGIN = 2,
    parameter int unsigned MAX_ADDR    = 307199
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prim_start,
    input  logic [COLOR_W-1:0] prim_color,
    input  logic [ADDR_W-1:0]  pix_addr,
    input  logic               pix_valid,
    input  logic               prim_done,
    output logic               stop,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [COLOR_W-1:0] sram_wdata,
    output logic               sram_we,
    input  logic               sram_ack,
    output logic               busy,
    output logic               write_done,
    output logic [15:0]        clip_count,
    output logic               overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_last_valid;
    logic [COLOR_W-1:0]  r_color;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic                r_sram_we;
    logic                r_stop;
    logic                r_busy;
    logic                r_write_done;
    logic [15:0]         r_clip_count;
    logic                r_overflow;

    logic                w_start;
    logic                w_in_pix;
    logic                w_clip;
    logic                w_dup;
    logic                w_push_req;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_lost;
    logic [CNT_W-1:0]    w_count_next;
    logic [CNT_W-1:0]    w_count_after_pop;
    logic [PTR_W-1:0]    w_rd_ptr_next;
    logic [ADDR_W-1:0]   w_head_next;
    logic                w_busy_next;
    logic                w_done_next;

    assign w_start           = (r_state == S_IDLE) && prim_start;
    assign w_in_pix          = (r_state == S_ACTIVE) && pix_valid;
    assign w_clip            = w_in_pix && (pix_addr > ADDR_W'(MAX_ADDR));
    assign w_dup             = w_in_pix && !w_clip && r_last_valid && (pix_addr == r_last_addr);
    assign w_push_req        = w_in_pix && !w_clip && !w_dup;
    assign w_full            = (r_count == CNT_W'(DEPTH));
    assign w_pop             = r_sram_we && sram_ack;
    // A full FIFO can still accept when its head leaves in the same cycle
    assign w_push            = w_push_req && (!w_full || w_pop);
    assign w_lost            = w_push_req && w_full && !w_pop;
    assign w_count_next      = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_rd_ptr_next     = r_rd_ptr + PTR_W'(w_pop);
    // With nothing left behind the popped head, the incoming pixel becomes the head
    assign w_head_next       = (w_count_after_pop == '0) ? pix_addr : r_mem[w_rd_ptr_next];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (prim_start) w_state_next = S_ACTIVE;
            S_ACTIVE: if (prim_done) w_state_next = S_DRAIN;
            S_DRAIN:  if ((r_count == '0) && !r_sram_we) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state, registered below
    always_comb begin
        w_busy_next = (w_state_next != S_IDLE);
        w_done_next = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pix_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_addr  <= '0;
            r_last_valid <= 1'b0;
            r_color      <= '0;
            r_sram_addr  <= '0;
            r_sram_we    <= 1'b0;
            r_stop       <= 1'b0;
            r_busy       <= 1'b0;
            r_write_done <= 1'b0;
            r_clip_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            r_sram_we    <= (w_count_next != '0);
            r_stop       <= (w_count_next >= CNT_W'(DEPTH - STOP_MARGIN));
            r_busy       <= w_busy_next;
            r_write_done <= w_done_next;
            if (w_count_next != '0) begin
                r_sram_addr <= w_head_next;
            end
            if (w_start) begin
                r_color      <= prim_color;
                r_clip_count <= '0;
                r_overflow   <= 1'b0;
                r_last_valid <= 1'b0;
            end else begin
                if (w_clip && (r_clip_count != 16'hFFFF)) begin
                    r_clip_count <= r_clip_count + 16'd1;
                end
                if (w_lost) begin
                    r_overflow <= 1'b1;
                end
                if (w_in_pix && !w_clip) begin
                    r_last_addr  <= pix_addr;
                    r_last_valid <= 1'b1;
                end
            end
        end
    end

    assign stop       = r_stop;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_color;
    assign sram_we    = r_sram_we;
    assign busy       = r_busy;
    assign write_done = r_write_done;
    assign clip_count = r_clip_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Directed bench for pixel_write_fifo: filtering, ordering, backpressure, overflow and reset.
module tb_pixel_write_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        prim_start;
    logic [7:0]  prim_color;
    logic [18:0] pix_addr;
    logic        pix_valid;
    logic        prim_done;
    logic        stop;
    logic [18:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_we;
    logic        sram_ack;
    logic        busy;
    logic        write_done;
    logic [15:0] clip_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    logic [18:0] wq[$];

    always #5 clk = ~clk;

    pixel_write_fifo dut (
        .clk(clk), .rst(rst), .prim_start(prim_start), .prim_color(prim_color),
        .pix_addr(pix_addr), .pix_valid(pix_valid), .prim_done(prim_done),
        .stop(stop), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_ack(sram_ack), .busy(busy),
        .write_done(write_done), .clip_count(clip_count), .overflow(overflow)
    );

    // Record every accepted SRAM write
    always @(posedge clk) begin
        if (!rst && sram_we && sram_ack) wq.push_back(sram_addr);
    end

    task automatic start_prim(input logic [7:0] c);
        prim_start = 1'b1;
        prim_color = c;
        @(negedge clk);
        prim_start = 1'b0;
    endtask

    task automatic send_pix(input logic [18:0] a, input logic done);
        pix_addr  = a;
        pix_valid = 1'b1;
        prim_done = done;
        @(negedge clk);
        pix_valid = 1'b0;
        prim_done = 1'b0;
    endtask

    task automatic wait_idle(output int pulses, output bit ok);
        pulses = 0;
        ok     = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (write_done) pulses++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (sram_we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%0b exp=0", sram_we); end
        total++; if (stop !== 1'b0)       begin bad++; $display("FAIL reset_stop got=%0b exp=0", stop); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (write_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", write_done); end
        total++; if (sram_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", sram_addr); end
        total++; if (sram_wdata !== 8'd0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", sram_wdata); end
        total++; if (clip_count !== 16'd0) begin bad++; $display("FAIL reset_clip got=%0d exp=0", clip_count); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int p; bit ok;
        wq.delete();
        sram_ack = 1'b1;
        start_prim(8'hA5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy); end
        send_pix(19'd153920, 1'b1);
        total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL single_lat_we got=%0b exp=1", sram_we); end
        total++; if (sram_addr !== 19'd153920) begin bad++; $display("FAIL single_addr got=%0d exp=153920", sram_addr); end
        total++; if (sram_wdata !== 8'hA5) begin bad++; $display("FAIL single_wdata got=%0h exp=a5", sram_wdata); end
        wait_idle(p, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
        total++; if (p !== 1) begin bad++; $display("FAIL single_done_pulses got=%0d exp=1", p); end
        total++; if (wq.size() !== 1 || wq[0] !== 19'd153920) begin bad++; $display("FAIL single_writes got_n=%0d exp_n=1", wq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_dups();
        int p; bit ok;
        logic [18:0] exp [3];
        exp = '{19'd100, 19'd101, 19'd100};
        wq.delete();
        sram_ack = 1'b1;
        start_prim(8'h11);
        send_pix(19'd100, 1'b0);
        send_pix(19'd100, 1'b0);
        send_pix(19'd101, 1'b0);
        send_pix(19'd100, 1'b1);
        wait_idle(p, ok);
        total++; if (wq.size() !== 3) begin bad++; $display("FAIL dups_count got=%0d exp=3", wq.size()); end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            total++; if (wq[i] !== exp[i]) begin bad++; $display("FAIL dups_order[%0d] got=%0d exp=%0d", i, wq[i], exp[i]); end
        end
        total++; if (clip_count !== 16'd0) begin bad++; $display("FAIL dups_clip got=%0d exp=0", clip_count); end
    endtask

    task automatic test_clip();
        int p; bit ok;
        wq.delete();
        sram_ack = 1'b1;
        start_prim(8'h22);
        send_pix(19'd307200, 1'b0);
        send_pix(19'd524287, 1'b0);
        send_pix(19'd5, 1'b1);
        wait_idle(p, ok);
        total++; if (wq.size() !== 1 || wq[0] !== 19'd5) begin bad++; $display("FAIL clip_writes got_n=%0d exp_n=1", wq.size()); end
        total++; if (clip_count !== 16'd2) begin bad++; $display("FAIL clip_count got=%0d exp=2", clip_count); end
    endtask

    task automatic test_stop();
        int p; bit ok;
        int sent = 0;
        int stop_at = -1;
        logic h1 = 1'b0, h2 = 1'b0, cur;
        wq.delete();
        sram_ack = 1'b0;
        start_prim(8'h42);
        // Rasterizer reacts to stop two cycles late
        for (int n = 0; n < 24; n++) begin
            cur = stop;
            if (cur && stop_at < 0) stop_at = sent;
            if (sent < 20 && !h2) begin pix_addr = 19'(1000 + sent); pix_valid = 1'b1; sent++; end
            else pix_valid = 1'b0;
            h2 = h1; h1 = cur;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        total++; if (stop_at !== 14) begin bad++; $display("FAIL stop_rise_at got=%0d exp=14", stop_at); end
        total++; if (sent !== 16) begin bad++; $display("FAIL stop_accepted got=%0d exp=16", sent); end
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL stop_held got=%0b exp=1", stop); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stop_ovf got=%0b exp=0", overflow); end
        total++; if (sram_addr !== 19'd1000) begin bad++; $display("FAIL stop_head_hold got=%0d exp=1000", sram_addr); end
        sram_ack = 1'b1;
        for (int n = 0; n < 80 && sent < 20; n++) begin
            cur = stop;
            if (!h2) begin pix_addr = 19'(1000 + sent); pix_valid = 1'b1; sent++; end
            else pix_valid = 1'b0;
            h2 = h1; h1 = cur;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        prim_done = 1'b1;
        @(negedge clk);
        prim_done = 1'b0;
        wait_idle(p, ok);
        total++; if (wq.size() !== 20) begin bad++; $display("FAIL stop_drain_count got=%0d exp=20", wq.size()); end
        for (int i = 0; i < wq.size() && i < 20; i++) begin
            total++; if (wq[i] !== 19'(1000 + i)) begin bad++; $display("FAIL stop_order[%0d] got=%0d exp=%0d", i, wq[i], 1000 + i); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stop_ovf_end got=%0b exp=0", overflow); end
    endtask

    task automatic test_steady();
        int p; bit ok;
        wq.delete();
        sram_ack = 1'b0;
        start_prim(8'h33);
        for (int i = 0; i < 13; i++) send_pix(19'(2000 + i), 1'b0);
        total++; if (stop !== 1'b0) begin bad++; $display("FAIL steady_stop13 got=%0b exp=0", stop); end
        total++; if (dut.r_count !== 5'd13) begin bad++; $display("FAIL steady_fill got=%0d exp=13", dut.r_count); end
        sram_ack = 1'b1;
        for (int i = 0; i < 50; i++) begin
            send_pix(19'(2013 + i), 1'b0);
            total++; if (stop !== 1'b0) begin bad++; $display("FAIL steady_stop[%0d] got=%0b exp=0", i, stop); end
            total++; if (dut.r_count !== 5'd13) begin bad++; $display("FAIL steady_count[%0d] got=%0d exp=13", i, dut.r_count); end
        end
        prim_done = 1'b1;
        @(negedge clk);
        prim_done = 1'b0;
        wait_idle(p, ok);
        total++; if (wq.size() !== 63) begin bad++; $display("FAIL steady_writes got=%0d exp=63", wq.size()); end
        for (int i = 0; i < wq.size() && i < 63; i++) begin
            if (wq[i] !== 19'(2000 + i)) begin
                total++; bad++; $display("FAIL steady_order[%0d] got=%0d exp=%0d", i, wq[i], 2000 + i);
                break;
            end
        end
    endtask

    task automatic test_overflow();
        int p; bit ok;
        wq.delete();
        sram_ack = 1'b0;
        start_prim(8'h77);
        for (int i = 0; i < 8; i++) send_pix(19'(3000 + i), 1'b0);
        prim_start = 1'b1; prim_color = 8'h3C;
        for (int i = 8; i < 17; i++) send_pix(19'(3000 + i), 1'b0);
        prim_start = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        total++; if (dut.r_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", dut.r_count); end
        total++; if (sram_wdata !== 8'h77) begin bad++; $display("FAIL ovf_busy_start got=%0h exp=77", sram_wdata); end
        sram_ack = 1'b1;
        prim_done = 1'b1;
        @(negedge clk);
        prim_done = 1'b0;
        wait_idle(p, ok);
        total++; if (wq.size() !== 16) begin bad++; $display("FAIL ovf_writes got=%0d exp=16", wq.size()); end
        total++; if (wq.size() == 16 && (wq[0] !== 19'd3000 || wq[15] !== 19'd3015)) begin bad++; $display("FAIL ovf_order got=%0d..%0d exp=3000..3015", wq[0], wq[15]); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        int p; bit ok;
        sram_ack = 1'b0;
        start_prim(8'h5A);
        for (int i = 0; i < 5; i++) send_pix(19'(4000 + i), 1'b0);
        total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL rmid_pre_we got=%0b exp=1", sram_we); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%0b exp=0", sram_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
        total++; if (stop !== 1'b0) begin bad++; $display("FAIL rmid_stop got=%0b exp=0", stop); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%0b exp=0", overflow); end
        wq.delete();
        sram_ack = 1'b1;
        start_prim(8'hC3);
        send_pix(19'd4321, 1'b1);
        total++; if (sram_addr !== 19'd4321) begin bad++; $display("FAIL rmid_new_addr got=%0d exp=4321", sram_addr); end
        total++; if (sram_wdata !== 8'hC3) begin bad++; $display("FAIL rmid_new_wdata got=%0h exp=c3", sram_wdata); end
        wait_idle(p, ok);
        total++; if (!ok || p !== 1) begin bad++; $display("FAIL rmid_done got=%0d exp=1", p); end
        total++; if (wq.size() !== 1 || wq[0] !== 19'd4321) begin bad++; $display("FAIL rmid_writes got_n=%0d exp_n=1", wq.size()); end
    endtask

    initial begin
        rst = 1'b1; prim_start = 1'b0; prim_color = 8'h00; pix_addr = '0;
        pix_valid = 1'b0; prim_done = 1'b0; sram_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_dups();
        test_clip();
        test_stop();
        test_steady();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
